// File: rtl/fetch_stage_if.sv
// IF/ID handshake bundle between fetch and decode.
// master: fetch drives valid/instr/pc/next_pc; slave: decode drives ready.
interface fetch_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [31:0]           instr;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] next_pc;

  modport master (
    output valid,
    output instr,
    output pc,
    output next_pc,
    input  ready
  );

  modport slave (
    input  valid,
    input  instr,
    input  pc,
    input  next_pc,
    output ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads ROM combinationally, fills IF/ID.
// Ports: clk/reset; rom_address/rom_data; out (IF/ID handshake);
//   redirect_valid/redirect_target; halt; halted/fault/fault_pc; fetch_count.
module fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [31:0]           rom_data,
  fetch_stage_if.master         out,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  halt,
  output logic                  halted,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_pc,
  output logic [31:0]           fetch_count
);

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    FAULT
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic                  misaligned;
  logic                  fire;

  assign rom_address = pc;
  // Truncation makes the top aligned address wrap to zero silently.
  assign pc_plus4    = pc + ADDR_WIDTH'(4);
  assign misaligned  = redirect_target[1:0] != 2'b00;
  assign fire        = out.valid && out.ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN) begin
      if (halt)
        state_d = HALTED;
      else if (redirect_valid && misaligned)
        state_d = FAULT;
    end
  end

  always_comb begin
    halted = (state_q == HALTED);
    fault  = (state_q == FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      out.valid   <= 1'b0;
      out.instr   <= '0;
      out.pc      <= '0;
      out.next_pc <= '0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      // Handshakes count in every state, even alongside halt/redirect.
      if (fire)
        fetch_count <= fetch_count + 32'd1;
      if (state_q == RUN) begin
        if (halt) begin
          out.valid <= 1'b0;
        end else if (redirect_valid && misaligned) begin
          fault_pc  <= redirect_target;
          out.valid <= 1'b0;
        end else if (redirect_valid) begin
          // Kill the in-flight word; refetch from target next cycle.
          pc        <= redirect_target;
          out.valid <= 1'b0;
        end else if (!out.valid || out.ready) begin
          out.instr   <= rom_data;
          out.pc      <= pc;
          out.next_pc <= pc_plus4;
          out.valid   <= 1'b1;
          pc          <= pc_plus4;
        end
      end else begin
        out.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected IF/ID words,
// per-DUT monitors pop and compare on every handshake.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  exp_t q1[$];
  exp_t q2[$];

  // DUT 1: 32-bit, RESET_PC 0
  fetch_stage_if #(.ADDR_WIDTH(32)) bus1();
  logic [31:0] rom_address1, rom_data1, target1, fault_pc1, count1;
  logic        redir1, halt1, halted1, fault1;

  assign rom_data1 = (rom_address1 >> 2) + 32'd100;

  fetch_stage #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut1 (
    .clk(clk), .reset(reset),
    .rom_address(rom_address1), .rom_data(rom_data1),
    .out(bus1),
    .redirect_valid(redir1), .redirect_target(target1),
    .halt(halt1), .halted(halted1), .fault(fault1),
    .fault_pc(fault_pc1), .fetch_count(count1)
  );

  // DUT 2: 8-bit, RESET_PC 0xF8 for wrap
  fetch_stage_if #(.ADDR_WIDTH(8)) bus2();
  logic [7:0]  rom_address2, fault_pc2;
  logic [31:0] rom_data2, count2;
  logic        halted2, fault2;

  assign rom_data2 = 32'(rom_address2 >> 2) + 32'd100;

  fetch_stage #(.ADDR_WIDTH(8), .RESET_PC(8'hF8)) dut2 (
    .clk(clk), .reset(reset),
    .rom_address(rom_address2), .rom_data(rom_data2),
    .out(bus2),
    .redirect_valid(1'b0), .redirect_target(8'h00),
    .halt(1'b0), .halted(halted2), .fault(fault2),
    .fault_pc(fault_pc2), .fetch_count(count2)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic push1(input logic [31:0] p, i, n);
    exp_t e;
    e.pc = p; e.instr = i; e.npc = n;
    q1.push_back(e);
  endtask

  task automatic push2(input logic [31:0] p, i, n);
    exp_t e;
    e.pc = p; e.instr = i; e.npc = n;
    q2.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && bus1.valid && bus1.ready) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon1_unexpected got_pc=%h want=none", bus1.pc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("mon1_pc", bus1.pc, e.pc);
        chk("mon1_instr", bus1.instr, e.instr);
        chk("mon1_next_pc", bus1.next_pc, e.npc);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus2.valid && bus2.ready) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL mon2_unexpected got_pc=%h want=none", bus2.pc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("mon2_pc", 32'(bus2.pc), e.pc);
        chk("mon2_instr", bus2.instr, e.instr);
        chk("mon2_next_pc", 32'(bus2.next_pc), e.npc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic wait_pc(input int which, input logic [31:0] v);
    for (int i = 0; i < 50; i++) begin
      if (which == 1 && bus1.valid && bus1.pc == v) return;
      if (which == 2 && bus2.valid && 32'(bus2.pc) == v) return;
      step();
    end
    checks++; failures++;
    $display("FAIL wait_pc%0d timeout got=none want=%h", which, v);
  endtask

  initial begin
    reset = 1'b1;
    bus1.ready = 1'b1;
    bus2.ready = 1'b0;
    redir1 = 1'b0;
    target1 = '0;
    halt1 = 1'b0;
    repeat (3) step();

    chk("rst_valid", 32'(bus1.valid), 32'd0);
    chk("rst_out_pc", bus1.pc, 32'h0);
    chk("rst_instr", bus1.instr, 32'h0);
    chk("rst_count", count1, 32'd0);
    chk("rst_rom", rom_address1, 32'h0);
    chk("rst_state", {30'd0, halted1, fault1}, 32'd0);
    chk("rst_rom2", 32'(rom_address2), 32'hF8);

    // Sequential fetch and stall
    push1(32'h0, 32'd100, 32'h4);
    push1(32'h4, 32'd101, 32'h8);
    push1(32'h8, 32'd102, 32'hC);
    push1(32'hC, 32'd103, 32'h10);
    reset = 1'b0;
    step();
    chk("first_valid", 32'(bus1.valid), 32'd1);
    chk("first_pc", bus1.pc, 32'h0);
    wait_pc(1, 32'h8);
    bus1.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus1.pc, 32'h8);
      chk("stall_instr", bus1.instr, 32'd102);
      chk("stall_rom", rom_address1, 32'hC);
      chk("stall_count", count1, 32'd2);
    end
    bus1.ready = 1'b1;
    step();
    chk("unstall_pc", bus1.pc, 32'hC);
    chk("unstall_count", count1, 32'd3);
    step();
    chk("count4", count1, 32'd4);
    bus1.ready = 1'b0;

    // Redirect while stalled
    push1(32'h0, 32'd100, 32'h4);
    bus1.ready = 1'b1;
    do_reset();
    wait_pc(1, 32'h4);
    bus1.ready = 1'b0;
    redir1 = 1'b1;
    target1 = 32'h40;
    step();
    redir1 = 1'b0;
    chk("redir_bubble", 32'(bus1.valid), 32'd0);
    chk("redir_rom", rom_address1, 32'h40);
    push1(32'h40, 32'd116, 32'h44);
    bus1.ready = 1'b1;
    step();
    chk("redir_valid", 32'(bus1.valid), 32'd1);
    chk("redir_pc", bus1.pc, 32'h40);
    chk("redir_instr", bus1.instr, 32'd116);
    step();
    bus1.ready = 1'b0;

    // Misaligned target faults; everything then ignored
    redir1 = 1'b1;
    target1 = 32'h42;
    step();
    chk("fault", 32'(fault1), 32'd1);
    chk("fault_pc", fault_pc1, 32'h42);
    chk("fault_valid", 32'(bus1.valid), 32'd0);
    chk("fault_rom", rom_address1, 32'h48);
    halt1 = 1'b1;
    target1 = 32'h80;
    bus1.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fault_hold", {30'd0, halted1, fault1}, 32'd1);
      chk("fault_pc_hold", fault_pc1, 32'h42);
      chk("fault_rom_hold", rom_address1, 32'h48);
      chk("fault_valid_hold", 32'(bus1.valid), 32'd0);
    end
    halt1 = 1'b0;
    redir1 = 1'b0;
    chk("fault_count", count1, 32'd2);
    bus1.ready = 1'b0;
    do_reset();
    chk("fault_cleared", 32'(fault1), 32'd0);
    chk("fault_rst_rom", rom_address1, 32'h0);

    // Halt wins over same-cycle redirect
    push1(32'h0, 32'd100, 32'h4);
    push1(32'h4, 32'd101, 32'h8);
    push1(32'h8, 32'd102, 32'hC);
    bus1.ready = 1'b1;
    wait_pc(1, 32'h8);
    halt1 = 1'b1;
    redir1 = 1'b1;
    target1 = 32'h100;
    step();
    halt1 = 1'b0;
    redir1 = 1'b0;
    chk("halted", {30'd0, halted1, fault1}, 32'd2);
    chk("halt_rom", rom_address1, 32'hC);
    chk("halt_count", count1, 32'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_valid", 32'(bus1.valid), 32'd0);
      chk("halt_rom_hold", rom_address1, 32'hC);
    end
    bus1.ready = 1'b0;
    do_reset();
    chk("halt_cleared", 32'(halted1), 32'd0);
    push1(32'h0, 32'd100, 32'h4);
    bus1.ready = 1'b1;
    step();
    chk("resume_pc", bus1.pc, 32'h0);
    chk("resume_valid", 32'(bus1.valid), 32'd1);
    step();
    bus1.ready = 1'b0;

    // PC wrap on 8-bit instance
    push2(32'hF8, 32'd162, 32'hFC);
    push2(32'hFC, 32'd163, 32'h00);
    push2(32'h00, 32'd100, 32'h04);
    push2(32'h04, 32'd101, 32'h08);
    bus2.ready = 1'b1;
    do_reset();
    wait_pc(2, 32'h08);
    bus2.ready = 1'b0;
    chk("wrap_fault", 32'(fault2), 32'd0);
    chk("wrap_halted", 32'(halted2), 32'd0);
    chk("wrap_fault_pc", 32'(fault_pc2), 32'h0);
    chk("wrap_rom", 32'(rom_address2), 32'h0C);
    chk("wrap_count", count2, 32'd4);

    repeat (2) step();
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RISC-V core.
- Owns the program counter and drives the instruction ROM's byte address, which it reads combinationally in the same cycle.
- Registers the returned instruction word together with its PC into an IF/ID output register, handed to decode via a valid/ready handshake.
- Handles redirects (branches/jumps), flushes, halt and misaligned-target faults.

Parameters:
- ADDR_WIDTH, default $bits(RomAddress), width of the PC and ROM byte address.
- RESET_PC, default 0, PC value loaded on reset.

Ports:
- clk  input  1  core clock; one clock; reset is synchronous and active-high.
- reset  input  1  synchronous, active-high reset.
- rom_address  output  ADDR_WIDTH  byte address to ROM; always equals pc.
- rom_data  input  32 (Word)  instruction word returned combinationally by ROM.
- out_valid  output  1  IF/ID register holds a valid instruction.
- out_ready  input  1  decode accepts the IF/ID contents this cycle.
- out_instr  output  32  registered instruction word.
- out_pc  output  ADDR_WIDTH  address of out_instr.
- out_next_pc  output  ADDR_WIDTH  out_pc + 4, modulo 2^ADDR_WIDTH.
- redirect_valid  input  1  branch/jump resolved taken; flush and refetch.
- redirect_target  input  ADDR_WIDTH  new PC for the redirect.
- halt  input  1  stop fetching (ecall/ebreak retire).
- halted  output  1  state == HALTED.
- fault  output  1  state == FAULT.
- fault_pc  output  ADDR_WIDTH  offending misaligned target.
- fetch_count  output  32  number of IF/ID handshakes completed.

Behaviour:
- Reset values:
  - pc = RESET_PC; state = RUN.
  - out_valid = 0; out_instr = 0; out_pc = 0; out_next_pc = 0.
  - fault_pc = 0; fetch_count = 0.
  - Reset overrides every other input, including mid-stall and mid-redirect.
- rom_address = pc combinationally, in all states.
- States: RUN, HALTED, FAULT.
- RUN, per cycle, in priority order:
  1. halt=1: go to HALTED; out_valid <= 0; pc holds. Halt wins over a same-cycle redirect.
  2. redirect_valid=1 with redirect_target[1:0] != 0: go to FAULT; fault_pc <= redirect_target; out_valid <= 0; pc holds.
  3. redirect_valid=1 with aligned target: pc <= redirect_target; out_valid <= 0 (in-flight instruction killed). Redirect wins over stall.
  4. out_valid=1 and out_ready=0 (stall): IF/ID register and pc hold exactly.
  5. Otherwise (out_valid=0, or out_ready=1): out_instr <= rom_data; out_pc <= pc; out_next_pc <= pc+4; out_valid <= 1; pc <= pc+4.
- fetch_count increments by 1 (wrapping at 2^32) on each cycle with out_valid && out_ready, in every state. A handshake in the same cycle as halt or redirect still counts.
- Latency:
  - Instruction at address A appears on out_instr one cycle after pc == A.
  - First valid output appears in the second cycle after reset deasserts.
  - After an aligned redirect: exactly one bubble cycle, then out_pc = target.
- Steady state with out_ready held at 1: one instruction per cycle, PCs consecutive +4.
- PC wrap: pc+4 truncated to ADDR_WIDTH, so max aligned address → 0. No fault is raised on wrap.
- HALTED and FAULT are terminal until reset:
  - out_valid = 0; pc frozen.
  - redirect, halt and out_ready are ignored.
  - fault_pc is stable in FAULT.
- Whenever out_valid=0 there is no handshake, regardless of out_ready.
- Debug trace: use the codebase TRACE macro on pc/out changes.

Test Plan:
- Reset with RESET_PC=0, ROM word[i]=i+100, out_ready=1 → out_pc sequence 0,4,8,12 with out_instr 100,101,102,103; fetch_count=4 after 4 handshakes.
- Stall: drop out_ready for 3 cycles while out_pc=8 → out_pc=8, out_instr=102, rom_address=12 held all 3 cycles. Raise out_ready → next out_pc=12; fetch_count increments once for pc 8.
- Redirect to 0x40 while stalled at out_pc=4 → next cycle out_valid=0, rom_address=0x40; following cycle out_pc=0x40, out_instr=ROM[16].
- Redirect to 0x42 → fault=1, fault_pc=0x42, out_valid=0. Later redirects and halt are ignored until reset; reset clears fault and restarts at 0.
- Halt and redirect in the same cycle → halted=1, pc unchanged, out_valid=0 forever; a pulse of reset resumes fetch from RESET_PC.
- PC wrap with ADDR_WIDTH=8, RESET_PC=0xF8 → out_pc 0xF8, 0xFC, 0x00, 0x04 with out_next_pc 0xFC, 0x00, 0x04, 0x08; no fault.
